incubator_plant: RTL and testbench

Cycle-based thermal model of the incubator chamber. It is the stimulus end of the controller's temperature interface: it consumes heater_on, cooler_on and cooler_rps, and produces the signed 8-bit chamber temperature T.
- T evolves once per prescaled tick: heater heating, fan-speed cooling, and drift toward ambient while both actuators are idle.
- Includes a load port for forcing T and sticky over/under-temperature alarms for closed-loop benches.

---
 rtl/incubator_pkg.sv | 38 +++
 rtl/incubator_plant_if.sv | 27 ++
 rtl/incubator_plant_tick_prescaler.sv | 29 ++
 rtl/incubator_plant.sv | 112 +++++++++++
 tb/tb_incubator_plant.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/incubator_pkg.sv
// Shared constants for the incubator chamber model and its controller bench:
// fan-speed codes, temperature limits and default set points.
package incubator_pkg;

   localparam logic [3:0] RPS_OFF  = 4'd0;
   localparam logic [3:0] RPS_LOW  = 4'd4;
   localparam logic [3:0] RPS_MID  = 4'd6;
   localparam logic [3:0] RPS_HIGH = 4'd8;

   localparam int T_MIN = -128;
   localparam int T_MAX = 127;

   localparam int TICK_DIV_DEFAULT  = 16;
   localparam int HEAT_STEP_DEFAULT = 2;
   localparam int DRIFT_DIV_DEFAULT = 4;

   localparam logic signed [7:0] T_INIT_DEFAULT    = 8'sd25;
   localparam logic signed [7:0] T_AMBIENT_DEFAULT = 8'sd20;
   localparam logic signed [7:0] ALARM_HI_DEFAULT  = 8'sd50;
   localparam logic signed [7:0] ALARM_LO_DEFAULT  = 8'sd0;

   typedef logic signed [7:0] temp_t;
   typedef logic signed [9:0] wide_temp_t;

   // Clamp a widened temperature back into the signed 8-bit range.
   function automatic temp_t sat_temp(input wide_temp_t value);
      temp_t result;
      if (value > wide_temp_t'(T_MAX)) begin
         result = 8'sd127;
      end else if (value < wide_temp_t'(T_MIN)) begin
         result = -8'sd128;
      end else begin
         result = value[7:0];
      end
      return result;
   endfunction

endpackage

// File: rtl/incubator_plant_if.sv
// Actuator, load and alarm signals between a controller (master) and the
// chamber model (slave).
interface incubator_plant_if;
   import incubator_pkg::*;

   logic        heater_on;
   logic        cooler_on;
   logic [3:0]  cooler_rps;
   logic        load_en;
   temp_t       load_value;
   logic        alarm_clr;
   temp_t       T;
   logic        t_valid;
   logic        alarm_hi;
   logic        alarm_lo;

   modport master (
      output heater_on, cooler_on, cooler_rps, load_en, load_value, alarm_clr,
      input  T, t_valid, alarm_hi, alarm_lo
   );

   modport slave (
      input  heater_on, cooler_on, cooler_rps, load_en, load_value, alarm_clr,
      output T, t_valid, alarm_hi, alarm_lo
   );

endinterface

// File: rtl/incubator_plant_tick_prescaler.sv
// Free-running modulo-TICK_DIV counter; tick is high for the last count of
// each period. A synchronous clear restarts the period from zero.
module tick_prescaler #(
   parameter int TICK_DIV = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (clr || (count_reg == LAST)) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign tick = (count_reg == LAST);

endmodule

// File: rtl/incubator_plant.sv
// Thermal model of the incubator chamber: once per prescaled tick the
// temperature moves by heater/cooler action or drifts toward ambient.
module incubator_plant
   import incubator_pkg::*;
#(
   parameter int    TICK_DIV  = TICK_DIV_DEFAULT,
   parameter temp_t T_INIT    = T_INIT_DEFAULT,
   parameter temp_t T_AMBIENT = T_AMBIENT_DEFAULT,
   parameter int    HEAT_STEP = HEAT_STEP_DEFAULT,
   parameter int    DRIFT_DIV = DRIFT_DIV_DEFAULT,
   parameter temp_t ALARM_HI  = ALARM_HI_DEFAULT,
   parameter temp_t ALARM_LO  = ALARM_LO_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   incubator_plant_if.slave bus
);

   localparam int DW = (DRIFT_DIV > 2) ? $clog2(DRIFT_DIV) : 1;
   localparam logic [DW-1:0] DRIFT_LAST = DW'(DRIFT_DIV - 1);

   temp_t         t_reg;
   logic          t_valid_reg;
   logic          alarm_hi_reg;
   logic          alarm_lo_reg;
   logic [DW-1:0] drift_cnt_reg;

   logic          tick;
   logic          idle;
   logic          drift_wrap;
   logic [3:0]    rps_half;
   wide_temp_t    heat_term;
   wide_temp_t    cool_term;
   wide_temp_t    drift_term;
   wide_temp_t    t_sum;
   temp_t         t_next;
   logic [DW-1:0] drift_cnt_next;

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (reset),
      .clr   (bus.load_en),
      .tick  (tick)
   );

   // Fan speed maps to cooling rate as rps/2, so rps 0 gives no cooling.
   assign rps_half   = bus.cooler_rps >> 1;
   assign idle       = !bus.heater_on && !bus.cooler_on;
   assign drift_wrap = (drift_cnt_reg == DRIFT_LAST);

   always_comb begin
      heat_term      = '0;
      cool_term      = '0;
      drift_term     = '0;
      drift_cnt_next = '0;
      if (bus.heater_on) begin
         heat_term = wide_temp_t'(HEAT_STEP);
      end
      if (bus.cooler_on) begin
         cool_term = {6'b0, rps_half};
      end
      if (idle) begin
         drift_cnt_next = drift_wrap ? '0 : drift_cnt_reg + 1'b1;
         if (drift_wrap) begin
            if (t_reg < T_AMBIENT) begin
               drift_term = 10'sd1;
            end else if (t_reg > T_AMBIENT) begin
               drift_term = -10'sd1;
            end
         end
      end
      t_sum  = {{2{t_reg[7]}}, t_reg} + heat_term - cool_term + drift_term;
      t_next = sat_temp(t_sum);
   end

   // A load overrides any tick landing on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         t_reg         <= T_INIT;
         drift_cnt_reg <= '0;
         t_valid_reg   <= 1'b0;
      end else begin
         t_valid_reg <= bus.load_en || tick;
         if (bus.load_en) begin
            t_reg         <= bus.load_value;
            drift_cnt_reg <= '0;
         end else if (tick) begin
            t_reg         <= t_next;
            drift_cnt_reg <= drift_cnt_next;
         end
      end
   end

   // Sticky alarms look at the registered temperature; a set beats a clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alarm_hi_reg <= 1'b0;
         alarm_lo_reg <= 1'b0;
      end else begin
         alarm_hi_reg <= (t_reg > ALARM_HI) || (alarm_hi_reg && !bus.alarm_clr);
         alarm_lo_reg <= (t_reg < ALARM_LO) || (alarm_lo_reg && !bus.alarm_clr);
      end
   end

   assign bus.T        = t_reg;
   assign bus.t_valid  = t_valid_reg;
   assign bus.alarm_hi = alarm_hi_reg;
   assign bus.alarm_lo = alarm_lo_reg;

endmodule

// File: tb/tb_incubator_plant.sv
// Directed and randomized bench for incubator_plant, checked every cycle
// against a behavioural model of the chamber rules.
module tb_incubator_plant;
   import incubator_pkg::*;

   localparam int TD = 4;
   localparam int DD = 2;
   localparam int HS = 2;
   localparam int TI = 25;
   localparam int TA = 20;
   localparam int AH = 50;
   localparam int AL = 0;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   incubator_plant_if bus();

   incubator_plant #(
      .TICK_DIV  (TD),
      .T_INIT    (8'sd25),
      .T_AMBIENT (8'sd20),
      .HEAT_STEP (HS),
      .DRIFT_DIV (DD),
      .ALARM_HI  (8'sd50),
      .ALARM_LO  (8'sd0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int vectors = 0;
   int miscompares = 0;

   // Model state: temperature, cycles into the current tick period, idle
   // ticks since the last drift step, and the output flags.
   int m_t;
   int m_phase;
   int m_idle;
   int m_valid;
   int m_hi;
   int m_lo;

   function automatic int clampi(input int v);
      if (v > 127) return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   task automatic model_reset();
      m_t = TI; m_phase = 0; m_idle = 0; m_valid = 0; m_hi = 0; m_lo = 0;
   endtask

   task automatic model_edge();
      int old_t;
      int is_tick;
      old_t   = m_t;
      is_tick = (m_phase == TD - 1);
      m_hi    = ((old_t > AH) || (m_hi != 0 && !bus.alarm_clr)) ? 1 : 0;
      m_lo    = ((old_t < AL) || (m_lo != 0 && !bus.alarm_clr)) ? 1 : 0;
      m_valid = (bus.load_en || is_tick != 0) ? 1 : 0;
      if (bus.load_en) begin
         m_t = int'($signed(bus.load_value));
         m_phase = 0;
         m_idle = 0;
      end else begin
         m_phase = (is_tick != 0) ? 0 : m_phase + 1;
         if (is_tick != 0) begin
            if (bus.heater_on || bus.cooler_on) begin
               m_t = clampi(m_t + (bus.heater_on ? HS : 0)
                            - (bus.cooler_on ? int'(bus.cooler_rps) / 2 : 0));
               m_idle = 0;
            end else begin
               m_idle++;
               if (m_idle == DD) begin
                  m_idle = 0;
                  if (m_t < TA) m_t++;
                  else if (m_t > TA) m_t--;
               end
            end
         end
      end
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      check("T", int'($signed(bus.T)), m_t);
      check("t_valid", int'(bus.t_valid), m_valid);
      check("alarm_hi", int'(bus.alarm_hi), m_hi);
      check("alarm_lo", int'(bus.alarm_lo), m_lo);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         model_edge();
         #1;
         check_all();
      end
   endtask

   task automatic drive(input logic h, input logic c, input logic [3:0] rps,
                        input logic ld, input int lv, input logic clr);
      bus.heater_on  = h;
      bus.cooler_on  = c;
      bus.cooler_rps = rps;
      bus.load_en    = ld;
      bus.load_value = 8'(lv);
      bus.alarm_clr  = clr;
   endtask

   task automatic load(input int lv, input logic h, input logic c,
                       input logic [3:0] rps, input logic clr);
      drive(h, c, rps, 1'b1, lv, clr);
      step(1);
      bus.load_en = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      drive(1'b0, 1'b0, RPS_OFF, 1'b0, 0, 1'b0);
      model_reset();
      #12;
      check_all();

      // Heating from reset: one +2 step per 4 cycles.
      @(posedge clk); #1;
      reset = 1'b1;
      bus.heater_on = 1'b1;
      step(20);
      check("heat_5_ticks", int'($signed(bus.T)), 35);

      // Cooling at rps 8, then rps 0 holds temperature.
      load(40, 1'b0, 1'b1, RPS_HIGH, 1'b0);
      step(12);
      check("cool_3_ticks", int'($signed(bus.T)), 28);
      bus.cooler_rps = RPS_OFF;
      step(8);
      check("cool_rps0_hold", int'($signed(bus.T)), 28);

      // Saturation at both ends.
      load(126, 1'b1, 1'b0, RPS_OFF, 1'b0);
      step(12);
      check("sat_hi", int'($signed(bus.T)), 127);
      load(-127, 1'b0, 1'b1, RPS_HIGH, 1'b0);
      step(12);
      check("sat_lo", int'($signed(bus.T)), -128);

      // Drift toward ambient while idle.
      load(30, 1'b0, 1'b0, RPS_OFF, 1'b1);
      step(8);
      check("drift_down_1", int'($signed(bus.T)), 29);
      step(8);
      check("drift_down_2", int'($signed(bus.T)), 28);
      load(18, 1'b0, 1'b0, RPS_OFF, 1'b1);
      step(8);
      check("drift_up", int'($signed(bus.T)), 19);
      load(20, 1'b0, 1'b0, RPS_OFF, 1'b1);
      step(8);
      check("drift_hold", int'($signed(bus.T)), 20);

      // Sticky alarms and clear priority.
      load(51, 1'b0, 1'b0, RPS_OFF, 1'b0);
      step(1);
      check("alarm_hi_set", int'(bus.alarm_hi), 1);
      load(30, 1'b0, 1'b0, RPS_OFF, 1'b0);
      step(1);
      check("alarm_hi_sticky", int'(bus.alarm_hi), 1);
      bus.alarm_clr = 1'b1;
      step(1);
      check("alarm_hi_clr", int'(bus.alarm_hi), 0);
      bus.alarm_clr = 1'b0;
      load(-1, 1'b0, 1'b0, RPS_OFF, 1'b0);
      step(1);
      check("alarm_lo_set", int'(bus.alarm_lo), 1);
      bus.alarm_clr = 1'b1;
      step(3);
      check("alarm_lo_set_wins", int'(bus.alarm_lo), 1);
      bus.alarm_clr = 1'b0;

      // Randomized actuators, loads and clears.
      repeat (400) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0),
               $urandom_range(0, 255) - 128, ($urandom_range(0, 7) == 0));
         step(1);
      end

      // Asynchronous reset mid-tick with alarm_hi set and T=40.
      load(60, 1'b0, 1'b0, RPS_OFF, 1'b0);
      step(1);
      load(40, 1'b0, 1'b0, RPS_OFF, 1'b0);
      step(1);
      check("pre_reset_hi", int'(bus.alarm_hi), 1);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check_all();
      check("async_reset_T", int'($signed(bus.T)), 25);
      @(posedge clk); #1;
      reset = 1'b1;
      bus.heater_on = 1'b1;
      step(3);
      check("no_early_tick", int'($signed(bus.T)), 25);
      step(1);
      check("first_tick", int'($signed(bus.T)), 27);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
